// File: rtl/powlib_skidbuff_if.sv
// Valid/ready handshake bundle for powlib_skidbuff: upstream (idata/ivld/irdy),
// downstream (odata/ovld/ordy) and the output transfer counter.
interface powlib_skidbuff_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic [W-1:0]  idata;
  logic          ivld;
  logic          irdy;
  logic [W-1:0]  odata;
  logic          ovld;
  logic          ordy;
  logic [CW-1:0] cnt;

  // master: the environment around the buffer (producer + consumer)
  modport master (
    output idata, ivld, ordy,
    input  irdy, odata, ovld, cnt
  );

  modport slave (
    input  idata, ivld, ordy,
    output irdy, odata, ovld, cnt
  );
endinterface

// File: rtl/powlib_skidbuff.sv
// Two-entry skid buffer: registered data/valid forward, registered ready back.
// Optional transfer counter enabled by defining POWLIB_SKIDBUFF_CNT_EN.
module powlib_skidbuff #(
  parameter int           W    = 8,
  parameter logic [W-1:0] INIT = '0,
  parameter int           CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  powlib_skidbuff_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q;
  logic         mv_q;
  logic         sv_q;
  logic [W-1:0] m_q;
  logic [W-1:0] s_q;

  assign bus.ovld  = mv_q;
  assign bus.odata = m_q;
  // Ready comes only from the skid flag, so ordy never reaches irdy combinationally.
  assign bus.irdy  = !sv_q && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      mv_q    <= 1'b0;
      sv_q    <= 1'b0;
      m_q     <= INIT;
      s_q     <= INIT;
    end else begin
      case (state_q)
        EMPTY: begin
          if (bus.ivld) begin
            m_q     <= bus.idata;
            mv_q    <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ivld && bus.ordy) begin
            m_q <= bus.idata;
          end else if (bus.ivld) begin
            // Consumer stalled while a new word arrived: park it in the skid slot.
            s_q     <= bus.idata;
            sv_q    <= 1'b1;
            state_q <= FULL;
          end else if (bus.ordy) begin
            mv_q    <= 1'b0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (bus.ordy) begin
            m_q     <= s_q;
            sv_q    <= 1'b0;
            state_q <= BUSY;
          end
        end
        default: begin
          mv_q    <= 1'b0;
          sv_q    <= 1'b0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

`ifdef POWLIB_SKIDBUFF_CNT_EN
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (mv_q && bus.ordy) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.cnt = cnt_q;
`else
  assign bus.cnt = '0;
`endif

endmodule

// File: doc/powlib_skidbuff.md
# powlib_skidbuff

Two-entry skid buffer with valid/ready handshake that feeds register stages such as the powlib flipflop pipeline. It registers data and valid on the forward path, and registers the ready signal back toward the producer so that long ready paths are broken. Full throughput is one transfer per cycle, with no bubble when the consumer stalls. It sits directly upstream of powlib_flipflop chains, where its `ovld`/`odata` drive the flipflop's `vld`/`d`.

## Interface
- `W`, default 8: data width.
- `INIT`, default 0: reset value of the main and skid data registers (`W` bits).
- `CW`, default 16: width of the transfer counter.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `idata`, input, W: upstream data.
- `ivld`, input, 1: upstream valid.
- `irdy`, output, 1: ready to upstream.
- `odata`, output, W: downstream data, driven by the main register.
- `ovld`, output, 1: downstream valid.
- `ordy`, input, 1: downstream ready.
- `cnt`, output, CW: count of completed output transfers.

## Operation
- Storage:
  - main register `m` with valid `mv`;
  - skid register `s` with valid `sv`.
- State machine:
  - EMPTY (`mv=0`, `sv=0`);
  - BUSY (`mv=1`, `sv=0`);
  - FULL (`mv=1`, `sv=1`).
- Decoded outputs: `ovld = mv`; `odata = m`; `irdy = !sv` gated low while `rst` is high.
- Input transfer: `ivld & irdy`. Output transfer: `ovld & ordy`.
- Transitions from EMPTY:
  - `ivld=1`: load `m <= idata` and go to BUSY.
  - Otherwise stay in EMPTY.
- Transitions from BUSY:
  - `ivld=1`, `ordy=1`: load `m <= idata` and stay in BUSY.
  - `ivld=1`, `ordy=0`: load `s <= idata` and go to FULL.
  - `ivld=0`, `ordy=1`: go to EMPTY.
  - `ivld=0`, `ordy=0`: hold.
- Transitions from FULL (`irdy=0`, so input is ignored):
  - `ordy=1`: load `m <= s` and go to BUSY.
  - Otherwise hold.
- Ordering: data leaves in strict arrival order. No word is dropped or duplicated.
- Data registers load only on the transitions listed above. Otherwise they hold, including while `ovld=0`.
- Stability: while `ovld=1` and `ordy=0`, `odata` and `ovld` stay constant.
- `ivld` is treated as don't-care when `irdy=0`. The upstream must hold `idata` until accepted, but this block does not check that.

## Timing
- Reset (asynchronous, effective immediately):
  - state goes to EMPTY;
  - `mv=0`, `sv=0`, `ovld=0`, `irdy=0`;
  - `m` and `s` load `INIT`, so `odata=INIT`;
  - `cnt=0`.
- `irdy` rises combinationally when `rst` deasserts. The first transfer can occur on the first rising edge after deassertion.
- Latency: a word accepted at edge N appears on `odata` with `ovld=1` after edge N.
- Throughput: with `ordy` held at 1, one word per cycle indefinitely, and the state stays BUSY.
- `irdy` depends only on registered state plus `rst`. There is no combinational path from `ordy` to `irdy`, or from `ivld` to `ovld`.
- Stall recovery: after FULL, `irdy` returns to 1 on the edge where FULL leaves for BUSY.
- Reset mid-operation discards buffered words. Partial transfers are not completed.

## Configuration
- Macro: `POWLIB_SKIDBUFF_CNT_EN`.
- Defined:
  - `cnt` increments by 1 on every output transfer;
  - it wraps from 2^CW-1 to 0;
  - reset value is 0.
- Undefined:
  - the counter logic is not compiled;
  - `cnt` is tied to 0;
  - the port list is unchanged.

## Test plan
- Reset: assert `rst` mid-cycle with `ivld=1` -> `ovld=0`, `irdy=0` and `odata=INIT` immediately. After release, `irdy=1` and `cnt=0`.
- Streaming: `W=8`, `ordy=1`, send 0x01..0x10 back-to-back -> `odata` shows 0x01..0x10 one cycle after each accept. There are no bubbles, and `cnt=16` (macro on).
- Stall: send 0xA1 then 0xA2 with `ordy=0` -> FULL, `irdy=0`, `odata=0xA1` held. Raise `ordy` -> 0xA1 then 0xA2 out on consecutive cycles, and `irdy=1` after the first.
- Random: random `ivld`/`ordy` (50%) for 10k cycles -> scoreboard shows in-order, lossless delivery, and `odata` is stable whenever `ovld & !ordy`.
- Counter wrap: `CW=4`, 17 output transfers -> `cnt` reads 15 then 0 then 1. With the macro undefined -> `cnt=0` throughout.
- Reset in FULL: reach FULL, then pulse `rst` -> both entries are discarded and the next input 0x55 is the first output.
